// File: rtl/krd_arb_pkg.sv
// Shared definitions for the channel frame arbiter: FSM encoding, default
// sizing, and the helper that derives the width of a channel index.
package krd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DROP   = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_N_CH       = 4;
    localparam int unsigned DEF_DATA_WIDTH = 256;

    // Bits needed to hold a channel index 0..n_ch-1 (at least one bit).
    function automatic int unsigned ch_id_width(input int unsigned n_ch);
        return (n_ch <= 2) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/channel_frame_arbiter_if.sv
// Bundle of the N-channel input streams and the merged output stream.
// master: the arbiter side; slave: the channel sources plus downstream sink.
interface channel_frame_arbiter_if
    import krd_arb_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CH_ID_WIDTH = 3
) ();

    logic [N_CH*DATA_WIDTH-1:0] S_TDATA;
    logic [N_CH-1:0]            S_TVALID;
    logic [N_CH-1:0]            S_TLAST;
    logic [N_CH-1:0]            S_TREADY;

    logic [DATA_WIDTH-1:0]      M_TDATA;
    logic                       M_TVALID;
    logic                       M_TLAST;
    logic [CH_ID_WIDTH-1:0]     M_TUSER;
    logic                       M_TREADY;

    modport master (
        input  S_TDATA, S_TVALID, S_TLAST, M_TREADY,
        output S_TREADY, M_TDATA, M_TVALID, M_TLAST, M_TUSER
    );

    modport slave (
        output S_TDATA, S_TVALID, S_TLAST, M_TREADY,
        input  S_TREADY, M_TDATA, M_TVALID, M_TLAST, M_TUSER
    );

endinterface

// File: rtl/rr_priority_sel.sv
// Rotating-priority selector: returns the first set request at or after
// start_i, wrapping around N_CH. Purely combinational.
module rr_priority_sel #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_o
);

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise a latch is inferred.
        grant_o = start_i;
        idx     = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = int'(start_i) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (req_i[idx]) begin
                grant_o = IDX_W'(idx);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/channel_frame_arbiter.sv
// Round-robin, frame-locked arbiter: merges whole frames from N channels onto
// one registered output stream, tags each frame with its channel, and cuts
// runaway frames at MAX_FRAME_WORDS (rest of the frame is drained and dropped).
module channel_frame_arbiter
    import krd_arb_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int MAX_FRAME_WORDS = 64,
    parameter int CH_ID_WIDTH     = 3
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic [N_CH-1:0]        CH_ENABLE,
    input  logic                   ERR_CLR,
    output logic [N_CH-1:0]        ERR_TRUNC,
    channel_frame_arbiter_if.master bus
);

    localparam int                IDX_W    = ch_id_width(N_CH);
    localparam int                WCNT_W   = $clog2(MAX_FRAME_WORDS);
    localparam logic [IDX_W-1:0]  LAST_CH  = IDX_W'(N_CH - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_FRAME_WORDS - 1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic                   m_tlast_q, m_tlast_d;
    logic [CH_ID_WIDTH-1:0] m_tuser_q, m_tuser_d;
    logic [N_CH-1:0]        err_q, err_d;

    logic [DATA_WIDTH-1:0]  ch_data [N_CH];
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_valid;
    logic                   sel_last;
    logic [N_CH-1:0]        s_tready;
    logic                   beat_acc;
    logic                   force_last;
    logic [IDX_W-1:0]       rr_start;
    logic [IDX_W-1:0]       rr_grant;
    logic                   rr_any;

    // Split the flat channel bus into per-channel words.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch_split
        assign ch_data[k] = bus.S_TDATA[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign sel_data   = ch_data[grant_q];
    assign sel_valid  = bus.S_TVALID[grant_q];
    assign sel_last   = bus.S_TLAST[grant_q];
    assign force_last = (wcnt_q == WCNT_MAX);

    // Search begins one past the channel that finished last, wrapping.
    assign rr_start = (last_grant_q == LAST_CH) ? '0 : last_grant_q + 1'b1;

    rr_priority_sel #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_rr_sel (
        .req_i   (bus.S_TVALID & CH_ENABLE),
        .start_i (rr_start),
        .grant_o (rr_grant),
        .any_o   (rr_any)
    );

    // Only the granted channel is ever ready; DROP drains it unconditionally.
    always_comb begin
        s_tready = '0;
        case (state_q)
            ST_STREAM: s_tready[grant_q] = ~m_tvalid_q | bus.M_TREADY;
            ST_DROP:   s_tready[grant_q] = 1'b1;
            default:   ;
        endcase
    end

    assign beat_acc     = sel_valid & s_tready[grant_q];
    assign bus.S_TREADY = s_tready;

    // Next-state, word counter, output register and error-flag update.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wcnt_d       = wcnt_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        m_tuser_d    = m_tuser_q;
        err_d        = ERR_CLR ? '0 : err_q;

        // Downstream consumed the held word; a new beat below may refill it.
        if (bus.M_TREADY) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    state_d = ST_STREAM;
                    grant_d = rr_grant;
                    wcnt_d  = '0;
                end
            end

            ST_STREAM: begin
                if (beat_acc) begin
                    m_tdata_d  = sel_data;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = sel_last | force_last;
                    m_tuser_d  = CH_ID_WIDTH'(grant_q);
                    if (!force_last) begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                    if (sel_last) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                    end else if (force_last) begin
                        // Set is applied after the clear, so it wins.
                        state_d        = ST_DROP;
                        err_d[grant_q] = 1'b1;
                    end
                end
            end

            ST_DROP: begin
                if (beat_acc && sel_last) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_CH;
            wcnt_q       <= '0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            m_tuser_q    <= '0;
            err_q        <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wcnt_q       <= wcnt_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            m_tuser_q    <= m_tuser_d;
            err_q        <= err_d;
        end
    end

    assign bus.M_TDATA  = m_tdata_q;
    assign bus.M_TVALID = m_tvalid_q;
    assign bus.M_TLAST  = m_tlast_q;
    assign bus.M_TUSER  = m_tuser_q;
    assign ERR_TRUNC    = err_q;

endmodule
